seq_shifter: RTL

//   Parametrised multi-cycle shifter; generalises the fixed shift-left-by-2 jump-address path.

---
 rtl/seq_shifter_if.sv | 25 ++
 rtl/seq_shifter.sv | 111 +++++++++++
 2 files changed

// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the control unit and seq_shifter.
// The master (control unit) issues requests and the slave (shifter) returns results.
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   din;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (
    output start, mode, shamt, din,
    input  busy, done, dout
  );

  modport slave (
    input  start, mode, shamt, din,
    output busy, done, dout
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTL shifter moving at most STEP bit positions per clock.
// The accept edge performs the first step, so busy covers only the remaining L-1 steps.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input logic          clk,
  input logic          rst,
  seq_shifter_if.slave bus
);
  localparam int unsigned        SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WidthAmt = (SHAMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [1:0]         r_mode;
  logic               r_sign;
  logic [SHAMT_W-1:0] r_rem;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_dout;

  logic               w_accepting;
  logic [WIDTH-1:0]   w_src;
  logic [1:0]         w_mode;
  logic               w_sign;
  logic [SHAMT_W-1:0] w_rem;
  logic [SHAMT_W-1:0] w_n;
  logic [SHAMT_W:0]   w_rot_amt;
  logic [WIDTH-1:0]   w_fill;
  logic [WIDTH-1:0]   w_step;
  logic [SHAMT_W-1:0] w_rem_next;

  // While accepting, the step operates directly on the incoming operands.
  always_comb begin
    w_accepting = (r_state != StShift);
    w_src       = w_accepting ? bus.din : r_work;
    w_mode      = w_accepting ? bus.mode : r_mode;
    w_sign      = w_accepting ? bus.din[WIDTH-1] : r_sign;
    w_rem       = w_accepting ? bus.shamt : r_rem;
    w_n         = (w_rem < StepAmt) ? w_rem : StepAmt;
    w_rot_amt   = WidthAmt - {1'b0, w_n};
    w_fill      = ~({WIDTH{1'b1}} >> w_n);
    w_rem_next  = w_rem - w_n;
    w_step      = w_src;
    unique case (w_mode)
      2'b00: w_step = w_src << w_n;
      2'b01: w_step = w_src >> w_n;
      2'b10: w_step = (w_src >> w_n) | (w_sign ? w_fill : '0);
      2'b11: w_step = (w_src << w_n) | (w_src >> w_rot_amt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_mode  <= 2'b00;
      r_sign  <= 1'b0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mode <= bus.mode;
            r_sign <= bus.din[WIDTH-1];
            r_work <= w_step;
            r_rem  <= w_rem_next;
            if (w_rem_next == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_dout  <= w_step;
            end else begin
              r_state <= StShift;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StShift: begin
          r_work <= w_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_dout  <= w_step;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dout = r_dout;
endmodule
